// File: rtl/psum_accum_pkg.sv
// Shared defaults, FSM state type and the per-lane add used by the Psum accumulator.
// ACC_SAT_EN selects a saturating lane add; otherwise the add wraps two's-complement.
package psum_accum_pkg;

   localparam int DEF_NUM_LANES = 36;
   localparam int DEF_PSUM_W    = 24;
   localparam int DEF_ACC_W     = 32;
   localparam int DEF_LEN_W     = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   // Operands arrive sign-extended to 64 bits; the result is sign-extended from bit w-1.
   function automatic logic [63:0] lane_add(input logic signed [63:0] a,
                                            input logic signed [63:0] b,
                                            input int unsigned        w);
      logic signed [64:0] s;
`ifdef ACC_SAT_EN
      logic signed [64:0] lim;
`endif
      s = {a[63], a} + {b[63], b};
`ifdef ACC_SAT_EN
      lim = (65'sd1 <<< (w - 1)) - 65'sd1;
      if (s > lim) begin
         s = lim;
      end else if (s < (-lim - 65'sd1)) begin
         s = -lim - 65'sd1;
      end
`endif
      s = (s <<< (65 - w)) >>> (65 - w);
      return s[63:0];
   endfunction

endpackage

// File: rtl/psum_accum_if.sv
// Psum input bus and finished-tile output handshake between producer/consumer and psum_accum.
interface psum_accum_if
   import psum_accum_pkg::*;
#(
   parameter int NUM_LANES = DEF_NUM_LANES,
   parameter int PSUM_W    = DEF_PSUM_W,
   parameter int ACC_W     = DEF_ACC_W
);

   logic                          psum_valid;
   logic [NUM_LANES*PSUM_W-1:0]   psum;
   logic                          out_valid;
   logic                          out_ready;
   logic [NUM_LANES*ACC_W-1:0]    out_data;

   modport master (
      output psum_valid, psum, out_ready,
      input  out_valid, out_data
   );

   modport slave (
      input  psum_valid, psum, out_ready,
      output out_valid, out_data
   );

endinterface

// File: rtl/psum_out_fifo.sv
// Two-entry tile buffer; a push into a full buffer succeeds only when a pop happens in the same cycle.
module psum_out_fifo #(
   parameter int WIDTH = 1152
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wrPtr_q;
   logic             rdPtr_q;
   logic [1:0]       count_q;
   logic             doPush;
   logic             doPop;

   assign full_o    = (count_q == 2'd2);
   assign empty_o   = (count_q == 2'd0);
   assign doPop     = pop_i && !empty_o;
   assign doPush    = push_i && (!full_o || doPop);
   assign rd_data_o = mem_q[rdPtr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wrPtr_q  <= 1'b0;
         rdPtr_q  <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (doPush) begin
            mem_q[wrPtr_q] <= wr_data_i;
            wrPtr_q        <= !wrPtr_q;
         end
         if (doPop) begin
            rdPtr_q <= !rdPtr_q;
         end
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/psum_accum.sv
// Per-lane Psum accumulator over acc_len beats, feeding finished tiles into a 2-entry output buffer.
// Build option: define ACC_SAT_EN for saturating lane adds (default wraps).
module psum_accum
   import psum_accum_pkg::*;
#(
   parameter int NUM_LANES = DEF_NUM_LANES,
   parameter int PSUM_W    = DEF_PSUM_W,
   parameter int ACC_W     = DEF_ACC_W,
   parameter int LEN_W     = DEF_LEN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [LEN_W-1:0] acc_len_i,
   input  logic             tile_clr_i,
   psum_accum_if.slave      bus,
   output logic             busy_o,
   output logic             overrun_o
);

   localparam int TILE_W = NUM_LANES * ACC_W;

   state_t                  state_q, state_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic [LEN_W-1:0]        cnt_q, cnt_d;
   logic [LEN_W-1:0]        effLen;
   logic [LEN_W-1:0]        cntNext;
   logic signed [ACC_W-1:0] acc_q [NUM_LANES];
   logic signed [ACC_W-1:0] acc_d [NUM_LANES];
   logic signed [ACC_W-1:0] sumLane [NUM_LANES];
   logic                    tileDone;
   logic                    pushPending_q, pushPending_d;
   logic                    overrun_q, overrun_d;
   logic                    fifoFull;
   logic                    fifoEmpty;
   logic [TILE_W-1:0]       accFlat;

   // The first beat of a tile adds onto zero, so one adder serves both load and accumulate.
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         sumLane[i] = ACC_W'(lane_add((state_q == IDLE) ? 64'sd0 : 64'(acc_q[i]),
                                      64'($signed(bus.psum[i*PSUM_W +: PSUM_W])),
                                      ACC_W));
      end
   end

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      tileDone = 1'b0;
      effLen   = (acc_len_i == '0) ? LEN_W'(1) : acc_len_i;
      cntNext  = cnt_q + 1'b1;
      if (tile_clr_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            acc_d[i] = '0;
         end
      end else if (bus.psum_valid) begin
         acc_d = sumLane;
         unique case (state_q)
            IDLE: begin
               len_d = effLen;
               cnt_d = LEN_W'(1);
               if (effLen == LEN_W'(1)) begin
                  tileDone = 1'b1;
               end else begin
                  state_d = ACCUM;
               end
            end
            ACCUM: begin
               cnt_d = cntNext;
               if (cntNext == len_q) begin
                  tileDone = 1'b1;
                  state_d  = IDLE;
               end
            end
         endcase
      end
   end

   // The finished sum sits in acc_q for one cycle and is pushed from there, even if a new tile loads.
   assign pushPending_d = tileDone;
   assign overrun_d     = overrun_q || (pushPending_q && fifoFull && !bus.out_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         len_q         <= '0;
         cnt_q         <= '0;
         pushPending_q <= 1'b0;
         overrun_q     <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) begin
            acc_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         cnt_q         <= cnt_d;
         pushPending_q <= pushPending_d;
         overrun_q     <= overrun_d;
         acc_q         <= acc_d;
      end
   end

   always_comb begin
      accFlat = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         accFlat[i*ACC_W +: ACC_W] = acc_q[i];
      end
   end

   psum_out_fifo #(
      .WIDTH(TILE_W)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_i   (pushPending_q),
      .pop_i    (bus.out_ready),
      .wr_data_i(accFlat),
      .rd_data_o(bus.out_data),
      .full_o   (fifoFull),
      .empty_o  (fifoEmpty)
   );

   assign bus.out_valid = !fifoEmpty;
   assign busy_o        = (state_q == ACCUM);
   assign overrun_o     = overrun_q;

endmodule
